// File: rtl/rvfi_channel_serializer_if.sv
// Bus bundle for rvfi_channel_serializer: multi-channel RVFI input side and single-channel output side.
interface rvfi_channel_serializer_if #(
   parameter int unsigned NRET  = 2,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned FW = $clog2(DEPTH) + 1;

   logic [NRET-1:0]      rvfi_valid;
   logic [64*NRET-1:0]   rvfi_order;
   logic [32*NRET-1:0]   rvfi_insn;
   logic [NRET-1:0]      rvfi_trap;
   logic [5*NRET-1:0]    rvfi_rs1_addr;
   logic [5*NRET-1:0]    rvfi_rs2_addr;
   logic [5*NRET-1:0]    rvfi_rd_addr;
   logic [XLEN*NRET-1:0] rvfi_rs1_rdata;
   logic [XLEN*NRET-1:0] rvfi_rs2_rdata;
   logic [XLEN*NRET-1:0] rvfi_rd_wdata;

   logic                 out_valid;
   logic [63:0]          out_order;
   logic [31:0]          out_insn;
   logic                 out_trap;
   logic [4:0]           out_rs1_addr;
   logic [XLEN-1:0]      out_rs1_rdata;
   logic [4:0]           out_rs2_addr;
   logic [XLEN-1:0]      out_rs2_rdata;
   logic [4:0]           out_rd_addr;
   logic [XLEN-1:0]      out_rd_wdata;
   logic [FW-1:0]        fill;
   logic                 overflow;
   logic                 order_error;

   // Producer side (core / bench)
   modport master (
      output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
             rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
      input  out_valid, out_order, out_insn, out_trap,
             out_rs1_addr, out_rs1_rdata, out_rs2_addr, out_rs2_rdata,
             out_rd_addr, out_rd_wdata, fill, overflow, order_error
   );

   // Serializer side
   modport slave (
      input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
             rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
      output out_valid, out_order, out_insn, out_trap,
             out_rs1_addr, out_rs1_rdata, out_rs2_addr, out_rs2_rdata,
             out_rd_addr, out_rd_wdata, fill, overflow, order_error
   );
endinterface

// File: rtl/rvfi_channel_serializer.sv
// Serializes up to NRET RVFI retirements per cycle into a one-per-cycle stream via a FIFO.
// Optional out_order continuity check enabled by `define RVFI_SERIALIZER_ORDER_CHECK_EN.
module rvfi_channel_serializer #(
   parameter int unsigned NRET  = 2,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 8
) (
   input logic                   clock,
   input logic                   reset,
   rvfi_channel_serializer_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef struct packed {
      logic [63:0]     order;
      logic [31:0]     insn;
      logic            trap;
      logic [4:0]      rs1_addr;
      logic [XLEN-1:0] rs1_rdata;
      logic [4:0]      rs2_addr;
      logic [XLEN-1:0] rs2_rdata;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] rd_wdata;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          ch_entry [NRET];
   entry_t          head_c;
   entry_t          out_q;
   logic [AW-1:0]   slot_c [NRET];
   logic [NRET-1:0] accept_c;
   logic [PW-1:0]   wr_ptr, rd_ptr, wr_nxt_c, rd_nxt_c;
   logic [PW-1:0]   count_c, free_c, n_push_c;
   logic [PW-1:0]   fill_q;
   logic            pop_c, bypass_c, advance_c, drop_c;
   logic            out_valid_q, overflow_q;

   // Unpack per-channel slices of the input buses
   always_comb begin
      for (int c = 0; c < NRET; c++) begin
         ch_entry[c].order     = bus.rvfi_order[c*64 +: 64];
         ch_entry[c].insn      = bus.rvfi_insn[c*32 +: 32];
         ch_entry[c].trap      = bus.rvfi_trap[c];
         ch_entry[c].rs1_addr  = bus.rvfi_rs1_addr[c*5 +: 5];
         ch_entry[c].rs1_rdata = bus.rvfi_rs1_rdata[c*XLEN +: XLEN];
         ch_entry[c].rs2_addr  = bus.rvfi_rs2_addr[c*5 +: 5];
         ch_entry[c].rs2_rdata = bus.rvfi_rs2_rdata[c*XLEN +: XLEN];
         ch_entry[c].rd_addr   = bus.rvfi_rd_addr[c*5 +: 5];
         ch_entry[c].rd_wdata  = bus.rvfi_rd_wdata[c*XLEN +: XLEN];
      end
   end

   // Admission: first `free` valid channels in index order; an empty FIFO forwards the first one directly
   always_comb begin
      count_c  = wr_ptr - rd_ptr;
      pop_c    = (count_c != '0);
      free_c   = PW'(DEPTH) - count_c + PW'(pop_c);
      n_push_c = '0;
      accept_c = '0;
      drop_c   = 1'b0;
      bypass_c = 1'b0;
      head_c   = mem[rd_ptr[AW-1:0]];
      for (int c = 0; c < NRET; c++) begin
         slot_c[c] = '0;
         if (bus.rvfi_valid[c] && !reset) begin
            if (n_push_c < free_c) begin
               accept_c[c] = 1'b1;
               slot_c[c]   = wr_ptr[AW-1:0] + n_push_c[AW-1:0];
               n_push_c    = n_push_c + PW'(1);
               if (!pop_c && !bypass_c) begin
                  head_c   = ch_entry[c];
                  bypass_c = 1'b1;
               end
            end else begin
               drop_c = 1'b1;
            end
         end
      end
      advance_c = pop_c || bypass_c;
      wr_nxt_c  = wr_ptr + n_push_c;
      rd_nxt_c  = rd_ptr + PW'(advance_c);
   end

   // FIFO storage, deliberately not reset
   always_ff @(posedge clock) begin
      for (int c = 0; c < NRET; c++) begin
         if (accept_c[c]) mem[slot_c[c]] <= ch_entry[c];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         out_q       <= '0;
      end else begin
         wr_ptr      <= wr_nxt_c;
         rd_ptr      <= rd_nxt_c;
         fill_q      <= wr_nxt_c - rd_nxt_c;
         out_valid_q <= advance_c;
         if (advance_c) out_q <= head_c;
         if (drop_c) overflow_q <= 1'b1;
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_order     = out_q.order;
   assign bus.out_insn      = out_q.insn;
   assign bus.out_trap      = out_q.trap;
   assign bus.out_rs1_addr  = out_q.rs1_addr;
   assign bus.out_rs1_rdata = out_q.rs1_rdata;
   assign bus.out_rs2_addr  = out_q.rs2_addr;
   assign bus.out_rs2_rdata = out_q.rs2_rdata;
   assign bus.out_rd_addr   = out_q.rd_addr;
   assign bus.out_rd_wdata  = out_q.rd_wdata;
   assign bus.fill          = fill_q;
   assign bus.overflow      = overflow_q;

`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
   logic [63:0] last_order;
   logic        seen_first;
   logic        order_error_q;

   // Every emitted order after the first must follow its predecessor by exactly one
   always_ff @(posedge clock) begin
      if (reset) begin
         last_order    <= '0;
         seen_first    <= 1'b0;
         order_error_q <= 1'b0;
      end else if (out_valid_q) begin
         if (seen_first && (out_q.order != last_order + 64'd1)) order_error_q <= 1'b1;
         last_order <= out_q.order;
         seen_first <= 1'b1;
      end
   end

   assign bus.order_error = order_error_q;
`else
   assign bus.order_error = 1'b0;
`endif
endmodule
